// File: rtl/hub_pkg.sv
// Shared definitions for the hub nonce arbiter: FSM encodings and fixed widths.
package hub_pkg;

    localparam int NONCE_W    = 32;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } hub_state_t;

endpackage

// File: rtl/hub_nonce_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo NUM_SLAVES.
module rr_arbiter
    import hub_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_SLAVES-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic [NUM_SLAVES-1:0] grant,
    output logic [IDX_W-1:0]      grant_idx
);

    logic [IDX_W-1:0] sel;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        // The last-granted source is visited last, which gives the fairness rotation.
        for (int k = 1; k <= NUM_SLAVES; k++) begin
            sel = IDX_W'((int'(ptr) + k) % NUM_SLAVES);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/hub_nonce_arbiter.sv
// Shares one upstream serial transmitter among NUM_SLAVES nonce sources with one-deep holding.
// Optional macro HUB_DROP_COUNT_EN adds a saturating drop_count output.
module hub_nonce_arbiter #(
    parameter int NUM_SLAVES = 4,
    parameter int NONCE_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SLAVES-1:0]         new_nonce,
    input  logic [NUM_SLAVES*NONCE_W-1:0] nonce_in,
    input  logic                          tx_busy,
    output logic                          tx_start,
    output logic [NONCE_W-1:0]            tx_data,
    output logic [NUM_SLAVES-1:0]         pending,
    output logic [NUM_SLAVES-1:0]         overflow
`ifdef HUB_DROP_COUNT_EN
    ,
    output logic [hub_pkg::DROP_CNT_W-1:0] drop_count
`endif
);
    import hub_pkg::*;

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    hub_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q;
    logic [NUM_SLAVES-1:0]  pend_q, ovf_q;
    logic [NUM_SLAVES-1:0]  grant, take, capture, drop;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_fire;
    logic [NONCE_W-1:0]     hold_q [NUM_SLAVES];

    rr_arbiter #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_rr (
        .req       (pend_q),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d    = state_q;
        tx_start   = 1'b0;
        grant_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    grant_fire = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // A source being granted this cycle frees its slot, so a same-cycle strobe is captured, not dropped.
    assign take    = grant_fire ? grant : '0;
    assign capture = new_nonce & (~pend_q | take);
    assign drop    = new_nonce & pend_q & ~take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_SLAVES - 1);
            pend_q  <= '0;
            ovf_q   <= '0;
            tx_data <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= (pend_q & ~take) | capture;
            ovf_q   <= ovf_q | drop;
            if (grant_fire) begin
                ptr_q   <= grant_idx;
                tx_data <= hold_q[grant_idx];
            end
        end
    end

    // Holding data needs no reset: occupancy lives in pend_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (capture[i]) hold_q[i] <= nonce_in[i*NONCE_W +: NONCE_W];
        end
    end

    assign pending  = pend_q;
    assign overflow = ovf_q;

`ifdef HUB_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                      input logic [DROP_CNT_W-1:0] b);
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= sat_add(drop_cnt_q, DROP_CNT_W'($countones(drop)));
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_hub_nonce_arbiter.sv
// Scoreboard bench for hub_nonce_arbiter: a cycle-timeline reference model predicts every transmit.
module tb_hub_nonce_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   new_nonce;
    logic [N*W-1:0] nonce_in;
    logic           tx_busy;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic [N-1:0]   pending;
    logic [N-1:0]   overflow;
`ifdef HUB_DROP_COUNT_EN
    logic [15:0]    drop_count;
`endif

    always #5 clk = ~clk;

    hub_nonce_arbiter #(.NUM_SLAVES(N), .NONCE_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .new_nonce (new_nonce),
        .nonce_in  (nonce_in),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .pending   (pending),
        .overflow  (overflow)
`ifdef HUB_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t expq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   lat = 40;
    int   bcnt = 0;
    bit   mon_en = 1'b0;

    // Reference model: slot per source, last-served index, cycle the link frees up.
    logic [W-1:0] m_hold [N];
    logic [N-1:0] m_pend, m_ovf;
    logic [W-1:0] m_txd;
    int           m_ptr, m_free, m_drops;

    // Values the DUT must show during the current cycle.
    logic [N-1:0] e_pend, e_ovf;
    logic [W-1:0] e_txd;
    int           e_drops;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_reset();
        m_pend  = '0;
        m_ovf   = '0;
        m_txd   = '0;
        m_ptr   = N - 1;
        m_free  = 0;
        m_drops = 0;
        e_pend  = '0;
        e_ovf   = '0;
        e_txd   = '0;
        e_drops = 0;
        expq.delete();
    endfunction

    // Source that the rules say is served in cycle 'at', or -1.
    function automatic int next_grant(input int at);
        if (at < m_free) return -1;
        for (int k = 1; k <= N; k++) begin
            if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] nn, input logic [N*W-1:0] nin);
        int   g;
        exp_t e;
        @(posedge clk);
        #1;
        e_pend    = m_pend;
        e_ovf     = m_ovf;
        e_txd     = m_txd;
        e_drops   = m_drops;
        new_nonce = nn;
        nonce_in  = nin;
        g = next_grant(cyc);
        if (g >= 0) begin
            e.data = m_hold[g];
            e.cyc  = cyc + 1;
            expq.push_back(e);
            m_txd     = m_hold[g];
            m_pend[g] = 1'b0;
            m_ptr     = g;
            m_free    = cyc + lat + 2;
        end
        for (int i = 0; i < N; i++) begin
            if (nn[i]) begin
                if (!m_pend[i]) begin
                    m_hold[i] = nin[i*W +: W];
                    m_pend[i] = 1'b1;
                end else begin
                    m_ovf[i] = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((expq.size() != 0 || cyc < m_free + 2 || tx_busy) && guard < 3000) begin
            step('0, '0);
            guard++;
        end
        if (guard >= 3000) chk("drain_timeout", 1, 0);
        idle(2);
    endtask

    task automatic do_reset();
        new_nonce = '0;
        nonce_in  = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
`ifdef HUB_DROP_COUNT_EN
        chk("rst_drop_count", drop_count, 0);
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Transmitter: busy for 'lat' cycles starting in the tx_start cycle.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !reset) bcnt = lat;
            tx_busy = (bcnt > 0);
            if (bcnt > 0) bcnt--;
        end
    end

    // Monitor: per-cycle state comparison and scoreboard pop on each tx_start.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                chk("pending", pending, e_pend);
                chk("overflow", overflow, e_ovf);
                chk("tx_data_held", tx_data, e_txd);
`ifdef HUB_DROP_COUNT_EN
                chk("drop_count", drop_count, e_drops);
`endif
                if (tx_start) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_tx_start", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("tx_start_data", tx_data, e.data);
                        chk("tx_start_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [N-1:0]   nn;
        logic [N*W-1:0] nb;
        int             grants, guard, g;
        bit             s2_sent;

        reset     = 1'b1;
        new_nonce = '0;
        nonce_in  = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("init_tx_start", tx_start, 0);
        chk("init_tx_data", tx_data, 0);
        chk("init_pending", pending, 0);
        chk("init_overflow", overflow, 0);

        // Single nonce on slave 2
        idle(6);
        nb = '0;
        nb[2*W +: W] = 32'hDEADBEEF;
        step(4'b0100, nb);
        drain();
        do_reset();

        // All four sources in one cycle, 40-cycle words
        nb = '0;
        for (int i = 0; i < N; i++) nb[i*W +: W] = 32'h1000_0000 + i;
        step(4'b1111, nb);
        drain();

        // Slave 1 second nonce dropped while slave 0 transmits
        nb = '0;
        nb[0 +: W] = 32'h0A0A0000;
        step(4'b0001, nb);
        idle(5);
        nb = '0;
        nb[1*W +: W] = 32'hAAAA0001;
        step(4'b0010, nb);
        idle(3);
        nb[1*W +: W] = 32'hAAAA0002;
        step(4'b0010, nb);
        idle(1);
        chk("t3_overflow1", overflow[1], 1);
`ifdef HUB_DROP_COUNT_EN
        chk("t3_drop_count", drop_count, 1);
`endif
        drain();

        // Slave 3 re-strobes on its own grant cycle
        nb = '0;
        nb[3*W +: W] = 32'h33330000;
        step(4'b1000, nb);
        guard = 0;
        while (next_grant(cyc + 1) != 3 && guard < 200) begin
            step('0, '0);
            guard++;
        end
        if (guard >= 200) chk("t4_grant_timeout", 1, 0);
        nb[3*W +: W] = 32'h33333333;
        step(4'b1000, nb);
        drain();
        chk("t4_overflow3", overflow[3], 0);

        // Reset in WAIT_DONE with slaves 1 and 2 pending
        nb = '0;
        nb[0 +: W] = 32'h50000000;
        step(4'b0001, nb);
        idle(4);
        nb = '0;
        nb[1*W +: W] = 32'h51111111;
        nb[2*W +: W] = 32'h52222222;
        step(4'b0110, nb);
        idle(10);
        do_reset();
        idle(60);
        drain();

        // Slaves 0 and 1 keep re-strobing on every grant; slave 2 joins midway
        lat = 3;
        nb = '0;
        nb[0 +: W]   = 32'h6000_0000;
        nb[1*W +: W] = 32'h6001_0000;
        step(4'b0011, nb);
        grants  = 0;
        guard   = 0;
        s2_sent = 1'b0;
        while (grants < 20 && guard < 2000) begin
            nn = '0;
            nb = '0;
            g  = next_grant(cyc + 1);
            if (g == 0 || g == 1) begin
                nn[g] = 1'b1;
                nb[g*W +: W] = 32'h6000_0000 | (g << 16) | (grants + 1);
                grants++;
            end
            if (grants == 10 && !s2_sent) begin
                nn[2] = 1'b1;
                nb[2*W +: W] = 32'h6002_0000;
                s2_sent = 1'b1;
            end
            step(nn, nb);
            guard++;
        end
        if (guard >= 2000) chk("t6_timeout", 1, 0);
        drain();

        // Randomised strobes
        lat = $urandom_range(2, 6);
        for (int t = 0; t < 800; t++) begin
            nn = '0;
            for (int i = 0; i < N; i++) begin
                nn[i] = ($urandom_range(0, 5) == 0);
                nb[i*W +: W] = $urandom;
            end
            step(nn, nb);
        end
        drain();
        chk("scoreboard_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
